// File: rtl/btb_2way_if.sv
// Commit-update and fetch-lookup signal bundle for the two-way BTB.
interface btb_2way_if;
  logic        rob_pop;
  logic [6:0]  commit_opcode;
  logic [31:0] commit_pc;
  logic [31:0] commit_target;
  logic        take_branch;
  logic [31:0] fetch_pc;
  logic        btb_hit;
  logic [31:0] btb_target;
  logic        btb_uncond;

  modport master (
    output rob_pop, commit_opcode, commit_pc, commit_target, take_branch, fetch_pc,
    input  btb_hit, btb_target, btb_uncond
  );

  modport slave (
    input  rob_pop, commit_opcode, commit_pc, commit_target, take_branch, fetch_pc,
    output btb_hit, btb_target, btb_uncond
  );
endinterface

// File: rtl/btb_2way.sv
// Two-way set-associative branch target buffer: combinational fetch lookup,
// commit-time non-speculative updates with one LRU bit per set.
module btb_2way #(
  parameter int IDX_BITS = 6
) (
  input logic     clk,
  input logic     rst,
  btb_2way_if.slave bus
);

  localparam int SETS     = 2 ** IDX_BITS;
  localparam int TAG_BITS = 30 - IDX_BITS;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic [1:0]          valid_q  [SETS];
  logic                lru_q    [SETS];
  logic [TAG_BITS-1:0] tag_q    [SETS][2];
  logic [31:0]         target_q [SETS][2];
  logic                uncond_q [SETS][2];

  logic [IDX_BITS-1:0] f_idx, c_idx;
  logic [TAG_BITS-1:0] f_tag, c_tag;
  logic                f_hit0, f_hit1;
  logic                c_hit0, c_hit1;
  logic                c_uncond, upd;
  logic                wr_way;
  logic                unused_low_bits;

  assign f_idx = bus.fetch_pc[IDX_BITS+1:2];
  assign f_tag = bus.fetch_pc[31:IDX_BITS+2];
  assign c_idx = bus.commit_pc[IDX_BITS+1:2];
  assign c_tag = bus.commit_pc[31:IDX_BITS+2];
  assign unused_low_bits = ^{bus.fetch_pc[1:0], bus.commit_pc[1:0]};

  assign f_hit0 = valid_q[f_idx][0] && (tag_q[f_idx][0] == f_tag);
  assign f_hit1 = valid_q[f_idx][1] && (tag_q[f_idx][1] == f_tag);

  // Lookup sees only registered state, so a same-cycle commit is not bypassed.
  always_comb begin
    bus.btb_hit    = 1'b0;
    bus.btb_target = 32'h0;
    bus.btb_uncond = 1'b0;
    if (f_hit0) begin
      bus.btb_hit    = 1'b1;
      bus.btb_target = target_q[f_idx][0];
      bus.btb_uncond = uncond_q[f_idx][0];
    end else if (f_hit1) begin
      bus.btb_hit    = 1'b1;
      bus.btb_target = target_q[f_idx][1];
      bus.btb_uncond = uncond_q[f_idx][1];
    end
  end

  assign c_uncond = (bus.commit_opcode == OP_JAL) || (bus.commit_opcode == OP_JALR);
  assign upd      = bus.rob_pop &&
                    (((bus.commit_opcode == OP_BRANCH) && bus.take_branch) || c_uncond);
  assign c_hit0   = valid_q[c_idx][0] && (tag_q[c_idx][0] == c_tag);
  assign c_hit1   = valid_q[c_idx][1] && (tag_q[c_idx][1] == c_tag);

  // Refresh a matching way; otherwise fill an empty way before evicting the LRU one.
  always_comb begin
    wr_way = lru_q[c_idx];
    if (c_hit0)                  wr_way = 1'b0;
    else if (c_hit1)             wr_way = 1'b1;
    else if (!valid_q[c_idx][0]) wr_way = 1'b0;
    else if (!valid_q[c_idx][1]) wr_way = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= 2'b00;
        lru_q[s]   <= 1'b0;
      end
    end else if (upd) begin
      valid_q[c_idx][wr_way] <= 1'b1;
      lru_q[c_idx]           <= ~wr_way;
    end
  end

  // Payload storage needs no reset; the valid bits guard it.
  always_ff @(posedge clk) begin
    if (rst && upd) begin
      tag_q[c_idx][wr_way]    <= c_tag;
      target_q[c_idx][wr_way] <= bus.commit_target;
      uncond_q[c_idx][wr_way] <= c_uncond;
    end
  end

endmodule

// File: tb/tb_btb_2way.sv
// Self-checking bench for btb_2way: directed scenarios then random traffic,
// scored against a recency-ordered entry list per set.
module tb_btb_2way;

  localparam int IDX_BITS = 6;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_ALU  = 7'b0110011;

  logic clk = 1'b0;
  logic rst;

  btb_2way_if bus ();

  btb_2way #(.IDX_BITS(IDX_BITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference: a flat list of resident entries keyed by pc[31:2]; stamp = last write time.
  typedef struct {
    logic [29:0] key;
    logic [31:0] target;
    logic        uncond;
    int          stamp;
  } entry_t;

  typedef struct {
    logic        hit;
    logic [31:0] target;
    logic        uncond;
    int          step;
  } exp_t;

  entry_t model[$];
  exp_t   sb[$];
  int     stamp_ctr = 0;
  int     step_ctr  = 0;
  int     checks    = 0;
  int     errors    = 0;

  logic [23:0] tag_pool [5] = '{24'h000010, 24'h000020, 24'h000030, 24'h800000, 24'hFFFFFF};
  logic [5:0]  idx_pool [3] = '{6'd0, 6'd1, 6'd63};

  function automatic exp_t modelLookup(input logic [31:0] pc);
    exp_t e;
    e.hit = 1'b0; e.target = 32'h0; e.uncond = 1'b0; e.step = 0;
    foreach (model[i]) begin
      if (model[i].key == pc[31:2]) begin
        e.hit    = 1'b1;
        e.target = model[i].target;
        e.uncond = model[i].uncond;
      end
    end
    return e;
  endfunction

  function automatic void modelCommit(input logic pop, input logic [6:0] opc,
                                      input logic [31:0] pc, input logic [31:0] tgt,
                                      input logic take);
    logic uncond;
    int   same, victim, oldest;
    entry_t n;
    uncond = (opc == OP_JAL) || (opc == OP_JALR);
    if (!pop || !(uncond || (opc == OP_BR && take))) return;
    stamp_ctr++;
    foreach (model[i]) begin
      if (model[i].key == pc[31:2]) begin
        model[i].target = tgt;
        model[i].uncond = uncond;
        model[i].stamp  = stamp_ctr;
        return;
      end
    end
    same = 0; victim = -1; oldest = 0;
    foreach (model[i]) begin
      if (model[i].key[IDX_BITS-1:0] == pc[IDX_BITS+1:2]) begin
        same++;
        if (victim < 0 || model[i].stamp < oldest) begin
          victim = i;
          oldest = model[i].stamp;
        end
      end
    end
    if (same >= 2) model.delete(victim);
    n.key = pc[31:2]; n.target = tgt; n.uncond = uncond; n.stamp = stamp_ctr;
    model.push_back(n);
  endfunction

  // Drive one cycle of inputs, queue the expected lookup, then advance the model at the edge.
  task automatic applyStimulus(input logic r, input logic pop, input logic [6:0] opc,
                               input logic [31:0] cpc, input logic [31:0] ctgt,
                               input logic take, input logic [31:0] fpc);
    exp_t e;
    rst               = r;
    bus.rob_pop       = pop;
    bus.commit_opcode = opc;
    bus.commit_pc     = cpc;
    bus.commit_target = ctgt;
    bus.take_branch   = take;
    bus.fetch_pc      = fpc;
    e      = modelLookup(fpc);
    e.step = step_ctr++;
    sb.push_back(e);
    @(posedge clk);
    if (!r) model.delete();
    else    modelCommit(pop, opc, cpc, ctgt, take);
    #1;
  endtask

  task automatic checkOutput(input exp_t e);
    checks++;
    if (bus.btb_hit !== e.hit || bus.btb_target !== e.target || bus.btb_uncond !== e.uncond) begin
      errors++;
      $display("[TB] FAIL lookup step=%0d fetch_pc=%h got hit=%b target=%h uncond=%b expected hit=%b target=%h uncond=%b",
               e.step, bus.fetch_pc, bus.btb_hit, bus.btb_target, bus.btb_uncond,
               e.hit, e.target, e.uncond);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) checkOutput(sb.pop_front());
  end

  function automatic logic [31:0] randPc();
    return {tag_pool[$urandom_range(0, 4)], idx_pool[$urandom_range(0, 2)], 2'($urandom_range(0, 3))};
  endfunction

  function automatic logic [6:0] randOp();
    case ($urandom_range(0, 3))
      0:       return OP_BR;
      1:       return OP_JAL;
      2:       return OP_JALR;
      default: return OP_ALU;
    endcase
  endfunction

  initial begin
    logic [31:0] cpc;
    rst = 1'b0;
    bus.rob_pop = 1'b0; bus.commit_opcode = OP_ALU; bus.commit_pc = 32'h0;
    bus.commit_target = 32'h0; bus.take_branch = 1'b0; bus.fetch_pc = 32'h0;
    repeat (2) @(posedge clk);
    #1;

    applyStimulus(1, 0, OP_ALU,  32'h0,    32'h0,    0, 32'h1000);
    applyStimulus(1, 1, OP_BR,   32'h1000, 32'h0F00, 1, 32'h1000);
    applyStimulus(1, 0, OP_ALU,  32'h0,    32'h0,    0, 32'h1000);
    applyStimulus(1, 1, OP_BR,   32'h2000, 32'h0123, 0, 32'h2000);
    applyStimulus(1, 0, OP_ALU,  32'h0,    32'h0,    0, 32'h2000);
    applyStimulus(1, 1, OP_BR,   32'h1000, 32'h0999, 0, 32'h1000);
    applyStimulus(1, 1, OP_ALU,  32'h1000, 32'h0888, 1, 32'h1000);
    applyStimulus(1, 0, OP_ALU,  32'h0,    32'h0,    0, 32'h1000);
    applyStimulus(1, 1, OP_JAL,  32'h1000, 32'h000A, 0, 32'h1000);
    applyStimulus(1, 1, OP_JAL,  32'h2000, 32'h000B, 0, 32'h1000);
    applyStimulus(1, 1, OP_JAL,  32'h3000, 32'h000C, 0, 32'h2000);
    applyStimulus(1, 0, OP_ALU,  32'h0,    32'h0,    0, 32'h1000);
    applyStimulus(1, 0, OP_ALU,  32'h0,    32'h0,    0, 32'h2000);
    applyStimulus(1, 0, OP_ALU,  32'h0,    32'h0,    0, 32'h3000);
    applyStimulus(1, 1, OP_JALR, 32'h2000, 32'h4444, 0, 32'h2000);
    applyStimulus(1, 0, OP_ALU,  32'h0,    32'h0,    0, 32'h2003);
    applyStimulus(1, 1, OP_JAL,  32'h5000, 32'h000D, 0, 32'h3000);
    applyStimulus(1, 0, OP_ALU,  32'h0,    32'h0,    0, 32'h3000);
    applyStimulus(1, 0, OP_ALU,  32'h0,    32'h0,    0, 32'h2000);
    applyStimulus(1, 0, OP_ALU,  32'h0,    32'h0,    0, 32'h5000);
    applyStimulus(1, 0, OP_JAL,  32'h6000, 32'h0066, 0, 32'h6000);
    applyStimulus(1, 0, OP_ALU,  32'h0,    32'h0,    0, 32'h6000);
    applyStimulus(0, 1, OP_JAL,  32'h7000, 32'h0077, 0, 32'h2000);
    applyStimulus(0, 1, OP_JAL,  32'h7000, 32'h0077, 0, 32'h2000);
    applyStimulus(1, 0, OP_ALU,  32'h0,    32'h0,    0, 32'h7000);
    applyStimulus(1, 0, OP_ALU,  32'h0,    32'h0,    0, 32'h2000);

    for (int i = 0; i < 600; i++) begin
      cpc = randPc();
      applyStimulus(($urandom_range(0, 63) != 0), ($urandom_range(0, 3) != 0), randOp(),
                    cpc, $urandom, 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 1) != 0) ? cpc : randPc());
    end

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
